// File: rtl/lm32_dp_ram_arb.sv
// Two-requester arbiter in front of a dual-port RAM (one write port, one
// registered read port). After reset, or on request, the RAM is zero-filled
// one word per cycle; the block then serves one A/B access per cycle with
// round-robin resolution of simultaneous requests.
module lm32_dp_ram_arb #(
  parameter int addr_width = 4,
  parameter int data_width = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [addr_width-1:0] a_addr_i,
  input  logic [data_width-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [data_width-1:0] a_rdata_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [addr_width-1:0] b_addr_i,
  input  logic [data_width-1:0] b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [data_width-1:0] b_rdata_o,
  output logic                  init_done_o,
  output logic                  ram_we_o,
  output logic [addr_width-1:0] ram_waddr_o,
  output logic [data_width-1:0] ram_wdata_o,
  output logic [addr_width-1:0] ram_raddr_o,
  input  logic [data_width-1:0] ram_rdata_i
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state_reg;
  logic [addr_width-1:0] count_reg;
  // 1 = B wins the next tie, 0 = A wins the next tie
  logic                  ptr_b_reg;
  logic                  a_rvalid_reg;
  logic                  b_rvalid_reg;

  logic                  run;
  logic                  filling;
  logic                  grant_a;
  logic                  grant_b;

  // Reset masks everything immediately, not just from the next edge.
  assign run     = (state_reg == RUN) && !rst_i;
  assign filling = (state_reg == CLEAR) && !rst_i;

  // Grant selection: a lone requester always wins, ties go to the pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (run) begin
      if (a_req_i && b_req_i) begin
        grant_a = !ptr_b_reg;
        grant_b = ptr_b_reg;
      end else begin
        grant_a = a_req_i;
        grant_b = b_req_i;
      end
    end
  end

  // RAM port steering: zero-fill writes while clearing, otherwise the granted access.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_waddr_o = count_reg;
    ram_wdata_o = '0;
    ram_raddr_o = a_addr_i;
    if (filling) begin
      ram_we_o = 1'b1;
    end else if (grant_a) begin
      ram_we_o    = a_we_i;
      ram_waddr_o = a_addr_i;
      ram_wdata_o = a_wdata_i;
      ram_raddr_o = a_addr_i;
    end else if (grant_b) begin
      ram_we_o    = b_we_i;
      ram_waddr_o = b_addr_i;
      ram_wdata_o = b_wdata_i;
      ram_raddr_o = b_addr_i;
    end
  end

  // FSM, fill counter, round-robin pointer and read-valid pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= CLEAR;
      count_reg    <= '0;
      ptr_b_reg    <= 1'b0;
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
    end else begin
      // A read granted now sees its data next cycle, even if clear_i leaves RUN.
      a_rvalid_reg <= grant_a && !a_we_i;
      b_rvalid_reg <= grant_b && !b_we_i;
      if (grant_a) begin
        ptr_b_reg <= 1'b1;
      end else if (grant_b) begin
        ptr_b_reg <= 1'b0;
      end
      case (state_reg)
        CLEAR: begin
          // Counter wraps back to zero as the last address is written.
          count_reg <= count_reg + 1'b1;
          if (count_reg == {addr_width{1'b1}}) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (clear_i) begin
            state_reg <= CLEAR;
            count_reg <= '0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign a_gnt_o     = grant_a;
  assign b_gnt_o     = grant_b;
  assign a_rvalid_o  = a_rvalid_reg && !rst_i;
  assign b_rvalid_o  = b_rvalid_reg && !rst_i;
  assign a_rdata_o   = ram_rdata_i;
  assign b_rdata_o   = ram_rdata_i;
  assign init_done_o = run;

endmodule

// File: tb/tb_lm32_dp_ram_arb.sv
// Bench for lm32_dp_ram_arb: a registered-read RAM model sits on the RAM
// ports, and a transaction-level reference model tracks memory contents,
// fill progress, tie-break history and outstanding reads.
module tb_lm32_dp_ram_arb;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          a_gnt;
  logic          b_gnt;
  logic          a_rvalid;
  logic          b_rvalid;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lm32_dp_ram_arb #(.addr_width(AW), .data_width(DW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .init_done_o(init_done),
    .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );

  // Dual-port RAM with registered read (returns pre-write contents on collision)
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rdata <= ram[ram_raddr];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [DEPTH];
  int            clear_left = DEPTH;  // fill words still to write; 0 = serving accesses
  bit            last_b = 1'b1;       // last grant went to B (so A wins a tie)
  int            pend = 0;            // read due this cycle: 0 none, 1 A, 2 B
  logic [DW-1:0] pend_data;

  bit            e_ga, e_gb, e_we, e_init, e_va, e_vb;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata, e_rdata;

  task automatic model_eval();
    e_ga = 0; e_gb = 0; e_we = 0; e_init = 0; e_va = 0; e_vb = 0;
    e_waddr = '0; e_wdata = '0; e_raddr = '0; e_rdata = pend_data;
    if (rst) return;
    e_va = (pend == 1);
    e_vb = (pend == 2);
    if (clear_left > 0) begin
      e_we = 1;
      e_waddr = AW'(DEPTH - clear_left);
    end else begin
      e_init = 1;
      if (a_req && b_req) begin
        if (last_b) e_ga = 1; else e_gb = 1;
      end else begin
        e_ga = a_req;
        e_gb = b_req;
      end
      if (e_ga) begin e_raddr = a_addr; e_we = a_we; e_waddr = a_addr; e_wdata = a_wdata; end
      if (e_gb) begin e_raddr = b_addr; e_we = b_we; e_waddr = b_addr; e_wdata = b_wdata; end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      clear_left = DEPTH; last_b = 1; pend = 0;
      return;
    end
    pend = 0;
    if (e_ga && !a_we) begin pend = 1; pend_data = mem[a_addr]; end
    if (e_gb && !b_we) begin pend = 2; pend_data = mem[b_addr]; end
    if (e_we) mem[e_waddr] = e_wdata;
    if (e_ga) last_b = 0;
    if (e_gb) last_b = 1;
    if (clear_left > 0) clear_left--;
    else if (clear) clear_left = DEPTH;
  endtask

  // Inputs are driven just after a rising edge; outputs are observed on the falling edge.
  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic end_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; clear = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 0;
    a_addr = 2; b_addr = 4; a_wdata = 32'h1234; b_wdata = 0;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      n_cmp++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, init_done} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b we=%b init=%b, want all 0",
                 a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, init_done);
      end
      end_cycle();
    end
    clear = 0;
  endtask

  task automatic test_zero_fill();
    rst = 0; a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    for (int i = 0; i < DEPTH; i++) begin
      eval_cycle();
      n_cmp++;
      if ({a_gnt, b_gnt, init_done} !== 3'b0) begin
        n_bad++;
        $display("FAIL fill_no_grant[%0d]: got gnt=%b%b init=%b, want 0", i, a_gnt, b_gnt, init_done);
      end
      n_cmp++;
      if (ram_we !== 1'b1 || ram_waddr !== AW'(i) || ram_wdata !== '0) begin
        n_bad++;
        $display("FAIL fill_write[%0d]: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=0",
                 i, ram_we, ram_waddr, ram_wdata, i);
      end
      end_cycle();
    end
    a_req = 0; b_req = 0;
    eval_cycle();
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_done: got init_done=%b, want 1", init_done);
    end
    end_cycle();
    $display("zero-fill of %0d words observed", DEPTH);
  endtask

  task automatic test_write_read();
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 32'hDEADBEEF; b_req = 0;
    eval_cycle();
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b10 || {ram_we, ram_waddr, ram_wdata} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL wr_access: got gnt=%b%b we=%b addr=%0d data=%h, want gnt=10 we=1 addr=3 data=deadbeef",
               a_gnt, b_gnt, ram_we, ram_waddr, ram_wdata);
    end
    end_cycle();
    $display("A write addr 3 data deadbeef");
    a_we = 0;
    eval_cycle();
    n_cmp++;
    if (a_gnt !== 1'b1 || ram_we !== 1'b0 || ram_raddr !== 4'd3) begin
      n_bad++;
      $display("FAIL rd_access: got gnt=%b we=%b raddr=%0d, want gnt=1 we=0 raddr=3", a_gnt, ram_we, ram_raddr);
    end
    end_cycle();
    a_req = 0;
    eval_cycle();
    n_cmp++;
    if ({a_rvalid, b_rvalid} !== 2'b10 || a_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_data: got rv=%b%b data=%h, want rv=10 data=deadbeef", a_rvalid, b_rvalid, a_rdata);
    end
    end_cycle();
    $display("A read addr 3 data %h", a_rdata);
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g;
    logic [1:0]    exp_v;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] got_d;
    b_req = 1; b_we = 0; b_addr = 5; a_req = 0;
    eval_cycle();
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL lone_b_grant: got gnt=%b%b, want 01", a_gnt, b_gnt);
    end
    end_cycle();
    a_req = 1; a_we = 0; a_addr = 3;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_req = 0; b_req = 0; end
      eval_cycle();
      if (k < 4) begin
        exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
        n_cmp++;
        if ({a_gnt, b_gnt} !== exp_g) begin
          n_bad++;
          $display("FAIL rr_grant[%0d]: got gnt=%b%b, want %b", k, a_gnt, b_gnt, exp_g);
        end
      end
      exp_v = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = exp_v[1] ? 32'hDEADBEEF : 32'h0;
      got_d = exp_v[1] ? a_rdata : b_rdata;
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== exp_v || got_d !== exp_d) begin
        n_bad++;
        $display("FAIL rr_rvalid[%0d]: got rv=%b%b data=%h, want rv=%b data=%h",
                 k, a_rvalid, b_rvalid, got_d, exp_v, exp_d);
      end
      end_cycle();
    end
    $display("round-robin A/B alternation observed");
  endtask

  task automatic test_read_before_write();
    b_req = 1; b_we = 1; b_addr = 5; b_wdata = 32'h55AA; a_req = 0;
    eval_cycle();
    end_cycle();
    b_we = 0;
    eval_cycle();
    end_cycle();
    b_req = 0; a_req = 1; a_we = 1; a_addr = 5; a_wdata = 32'h1;
    eval_cycle();
    n_cmp++;
    if (a_gnt !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== 32'h55AA) begin
      n_bad++;
      $display("FAIL rbw_old: got a_gnt=%b b_rv=%b data=%h, want 1 1 000055aa", a_gnt, b_rvalid, b_rdata);
    end
    end_cycle();
    a_req = 0; b_req = 1; b_we = 0;
    eval_cycle();
    end_cycle();
    b_req = 0;
    eval_cycle();
    n_cmp++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h1) begin
      n_bad++;
      $display("FAIL rbw_new: got b_rv=%b data=%h, want 1 00000001", b_rvalid, b_rdata);
    end
    end_cycle();
    $display("B read addr 5 old=55aa new=%h", b_rdata);
  endtask

  task automatic test_clear();
    clear = 1; a_req = 1; a_we = 0; a_addr = 3; b_req = 0;
    eval_cycle();
    n_cmp++;
    if (a_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_same_cycle_grant: got %b, want 1", a_gnt);
    end
    end_cycle();
    for (int i = 1; i <= DEPTH; i++) begin
      clear = (i == 6);
      eval_cycle();
      n_cmp++;
      if ({a_gnt, b_gnt, init_done} !== 3'b0 || ram_we !== 1'b1 || ram_waddr !== AW'(i - 1)) begin
        n_bad++;
        $display("FAIL clear_fill[%0d]: got gnt=%b%b init=%b we=%b addr=%0d, want 000 we=1 addr=%0d",
                 i, a_gnt, b_gnt, init_done, ram_we, ram_waddr, i - 1);
      end
      if (i == 1) begin
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL clear_pending_read: got rv=%b data=%h, want 1 deadbeef", a_rvalid, a_rdata);
        end
      end
      end_cycle();
    end
    clear = 0;
    eval_cycle();
    n_cmp++;
    if (a_gnt !== 1'b1 || init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_resume: got gnt=%b init=%b, want 1 1", a_gnt, init_done);
    end
    end_cycle();
    a_req = 0;
    eval_cycle();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL clear_zeroed: got rv=%b data=%h, want 1 00000000", a_rvalid, a_rdata);
    end
    end_cycle();
    $display("A read addr 3 after clear data %h", a_rdata);
  endtask

  task automatic test_reset_mid_op();
    a_req = 1; a_we = 0; a_addr = 3; b_req = 0;
    eval_cycle();
    end_cycle();
    a_req = 0; rst = 1;
    eval_cycle();
    n_cmp++;
    if ({a_rvalid, b_rvalid, ram_we, init_done} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_drop_read: got rv=%b%b we=%b init=%b, want 0000", a_rvalid, b_rvalid, ram_we, init_done);
    end
    end_cycle();
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      eval_cycle();
      n_cmp++;
      if (a_rvalid !== 1'b0 || ram_we !== 1'b1 || ram_waddr !== AW'(i)) begin
        n_bad++;
        $display("FAIL rst_fill1[%0d]: got rv=%b we=%b addr=%0d, want 0 1 %0d", i, a_rvalid, ram_we, ram_waddr, i);
      end
      end_cycle();
    end
    rst = 1;
    eval_cycle();
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_at_7: got we=%b, want 0", ram_we);
    end
    end_cycle();
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      eval_cycle();
      n_cmp++;
      if (init_done !== 1'b0 || ram_we !== 1'b1 || ram_waddr !== AW'(i)) begin
        n_bad++;
        $display("FAIL rst_fill2[%0d]: got init=%b we=%b addr=%0d, want 0 1 %0d", i, init_done, ram_we, ram_waddr, i);
      end
      end_cycle();
    end
    eval_cycle();
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_fill_done: got init=%b, want 1", init_done);
    end
    end_cycle();
    $display("reset during fill restarted at address 0");
  endtask

  task automatic test_random();
    a_req = 0; b_req = 0;
    for (int c = 0; c < 600; c++) begin
      if (!a_req || e_ga) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
        a_addr = AW'($urandom); a_wdata = $urandom;
      end
      if (!b_req || e_gb) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1);
        b_addr = AW'($urandom); b_wdata = $urandom;
      end
      rst   = ($urandom_range(0, 249) == 0);
      clear = ($urandom_range(0, 79) == 0);
      eval_cycle();
      n_cmp++;
      if ({a_gnt, b_gnt} !== {e_ga, e_gb}) begin
        n_bad++;
        $display("FAIL rnd_grant[%0d]: got %b%b, want %b%b", c, a_gnt, b_gnt, e_ga, e_gb);
      end
      n_cmp++;
      if ({a_rvalid, b_rvalid, init_done, ram_we} !== {e_va, e_vb, e_init, e_we}) begin
        n_bad++;
        $display("FAIL rnd_status[%0d]: got rv=%b%b init=%b we=%b, want rv=%b%b init=%b we=%b",
                 c, a_rvalid, b_rvalid, init_done, ram_we, e_va, e_vb, e_init, e_we);
      end
      if (e_we) begin
        n_cmp++;
        if (ram_waddr !== e_waddr || ram_wdata !== e_wdata) begin
          n_bad++;
          $display("FAIL rnd_wport[%0d]: got %0d/%h, want %0d/%h", c, ram_waddr, ram_wdata, e_waddr, e_wdata);
        end
      end
      if (e_ga || e_gb) begin
        n_cmp++;
        if (ram_raddr !== e_raddr) begin
          n_bad++;
          $display("FAIL rnd_raddr[%0d]: got %0d, want %0d", c, ram_raddr, e_raddr);
        end
      end
      if (e_va || e_vb) begin
        n_cmp++;
        if ((e_va ? a_rdata : b_rdata) !== e_rdata) begin
          n_bad++;
          $display("FAIL rnd_rdata[%0d]: got %h, want %h", c, e_va ? a_rdata : b_rdata, e_rdata);
        end
      end
      end_cycle();
    end
    rst = 0; clear = 0; a_req = 0; b_req = 0;
    $display("random traffic: 600 cycles");
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_write_read();
    test_round_robin();
    test_read_before_write();
    test_clear();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lm32_dp_ram_arb.md
LM32_DP_RAM_ARB -- requirements
Module: lm32_dp_ram_arb

Interface
REQ-001 SHALL have parameter addr_width, default 4, giving the RAM address width (depth = 2^addr_width).
REQ-002 SHALL have parameter data_width, default 32, giving the RAM data width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1, a request to re-run the zero-fill sequence.
REQ-006 SHALL have ports a_req_i / b_req_i, input, 1, the per-requester access request.
REQ-007 SHALL have ports a_we_i / b_we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports a_addr_i / b_addr_i, input, addr_width, the access address.
REQ-009 SHALL have ports a_wdata_i / b_wdata_i, input, data_width, the write data.
REQ-010 SHALL have ports a_gnt_o / b_gnt_o, output, 1, a combinational grant; the access completes in the cycle it is granted.
REQ-011 SHALL have ports a_rvalid_o / b_rvalid_o, output, 1, marking read data valid.
REQ-012 SHALL have ports a_rdata_o / b_rdata_o, output, data_width, the read data.
REQ-013 SHALL have port init_done_o, output, 1, high when the state is RUN.
REQ-014 SHALL have ports ram_we_o (1), ram_waddr_o (addr_width), ram_wdata_o (data_width) and ram_raddr_o (addr_width), all outputs, driving the dual-port RAM.
REQ-015 SHALL have port ram_rdata_i, input, data_width, the RAM read data; the RAM registers raddr, so data is valid one cycle after the address is presented.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-017 In CLEAR, SHALL drive ram_we_o=1, ram_waddr_o=clear counter and ram_wdata_o=0 every cycle.
REQ-018 In CLEAR, SHALL increment the counter each cycle, keep both grants low, and move to RUN in the cycle after writing address 2^addr_width-1; zero-fill takes exactly 2^addr_width cycles.
REQ-019 In RUN, SHALL grant at most one requester per cycle.
REQ-020 If only one requester is asserting req, SHALL grant that requester.
REQ-021 If both are asserting req, SHALL grant the requester selected by a round-robin pointer.
REQ-022 After each grant, the pointer SHALL point to the requester that was not granted; the pointer SHALL not change in cycles with no grant.
REQ-023 For a granted write, SHALL drive ram_we_o=1 with the granted addr/wdata in the same cycle; otherwise ram_we_o SHALL be 0.
REQ-024 ram_raddr_o SHALL carry the granted requester's address in every granted cycle.
REQ-025 For a granted read at cycle N, SHALL pulse that requester's rvalid_o in cycle N+1 (one cycle) with rdata_o = ram_rdata_i; the other rvalid_o SHALL be 0.
REQ-026 Throughput SHALL be one access per cycle: back-to-back reads SHALL give consecutive rvalid pulses.
REQ-027 A read at N+1 of an address written at N SHALL return the new data; a read at N followed by a write to the same address at N+1 SHALL return the old data (no bypass needed).
REQ-028 rdata_o SHALL be ram_rdata_i passed straight through; its value is don't-care when rvalid_o=0.
REQ-029 clear_i=1 in RUN SHALL move to CLEAR with counter=0; a read granted in that same cycle SHALL still receive its rvalid next cycle.
REQ-030 clear_i SHALL be ignored while in CLEAR (no counter restart).
REQ-031 Requests not granted SHALL be held by the requester until granted; the block SHALL not queue requests.

Reset
REQ-032 While rst_i=1, the FSM SHALL be set to CLEAR, the counter to 0 and the round-robin pointer to A.
REQ-033 While rst_i=1, all gnt, rvalid, ram_we_o and init_done_o outputs SHALL be 0.
REQ-034 Reset asserted mid-CLEAR or mid-RUN SHALL abort the operation: zero-fill restarts from address 0 and pending rvalid pulses are dropped.
REQ-035 The clear sequence SHALL begin in the first cycle after rst_i deasserts.

Verification (addr_width=4)
REQ-036 Release reset -> ram_we_o=1 for 16 cycles at addresses 0..15 with data 0; init_done_o rises in cycle 17; no grants before then.
REQ-037 A writes 0xDEADBEEF to address 3, then A reads address 3 -> a_rvalid_o one cycle after the read grant with a_rdata_o=0xDEADBEEF.
REQ-038 A and B hold req for 4 cycles -> grants go A,B,A,B; rvalid pulses go to the matching requester one cycle later.
REQ-039 clear_i during RUN, then read address 3 -> no grant for 16 cycles, then a_rdata_o=0.
REQ-040 rst_i pulsed at clear address 7 -> zero-fill restarts at address 0 and init_done_o stays low for 16 more cycles.
REQ-041 B reads address 5 at N while A writes 0x1 to address 5 at N+1 -> b_rdata_o at N+1 returns the old value.
